// File: rtl/imm_pkg.sv
// imm_pkg: immediate format encodings, RISC-V opcode constants and opcode-to-format mapping
package imm_pkg;
  typedef enum logic [2:0] {
    FMT_I     = 3'b000,
    FMT_S     = 3'b001,
    FMT_B     = 3'b010,
    FMT_U     = 3'b011,
    FMT_J     = 3'b100,
    FMT_SHAMT = 3'b101,
    FMT_ZIMM  = 3'b110,
    FMT_ILL   = 3'b111
  } imm_fmt_e;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  function automatic imm_fmt_e auto_fmt(input logic [31:0] inst);
    logic [2:0] f3;
    f3 = inst[14:12];
    case (inst[6:0])
      OP_LOAD, OP_JALR: auto_fmt = FMT_I;
      OP_IMM:           auto_fmt = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SHAMT : FMT_I;
      OP_STORE:         auto_fmt = FMT_S;
      OP_BRANCH:        auto_fmt = FMT_B;
      OP_LUI, OP_AUIPC: auto_fmt = FMT_U;
      OP_JAL:           auto_fmt = FMT_J;
      OP_SYSTEM:        auto_fmt = f3[2] ? FMT_ZIMM : FMT_I;
      default:          auto_fmt = FMT_ILL;
    endcase
  endfunction
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational immediate format selection and extraction
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b0
) (
  input  logic [31:0]     i_inst,
  input  logic [2:0]      i_imm_src,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal
);
  imm_fmt_e w_fmt;
  assign w_fmt     = AUTO_DECODE ? auto_fmt(i_inst) : imm_fmt_e'(i_imm_src);
  assign o_illegal = (w_fmt == FMT_ILL);
  always_comb begin
    o_imm = '0;
    case (w_fmt)
      FMT_I:     o_imm = XLEN'($signed(i_inst[31:20]));
      FMT_S:     o_imm = XLEN'($signed({i_inst[31:25], i_inst[11:7]}));
      FMT_B:     o_imm = XLEN'($signed({i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0}));
      FMT_U:     o_imm = XLEN'($signed({i_inst[31:12], 12'b0}));
      FMT_J:     o_imm = XLEN'($signed({i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0}));
      FMT_SHAMT: o_imm = (XLEN == 32) ? XLEN'(i_inst[24:20]) : XLEN'(i_inst[25:20]);
      FMT_ZIMM:  o_imm = XLEN'(i_inst[19:15]);
      default:   o_imm = '0;
    endcase
  end
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate generator with valid/ready handshake and illegal-request counter
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b0,
  parameter int TAG_W       = 5,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [2:0]       imm_src,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] illegal_cnt
);
  logic             r_valid;
  logic [XLEN-1:0]  r_imm;
  logic [TAG_W-1:0] r_tag;
  logic             r_ill;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  w_imm;
  logic             w_ill;
  logic             w_acc;
  imm_decode #(.XLEN(XLEN), .AUTO_DECODE(AUTO_DECODE)) u_dec (
    .i_inst(in_inst), .i_imm_src(imm_src), .o_imm(w_imm), .o_illegal(w_ill)
  );
  assign in_ready = !r_valid || out_ready;
  assign w_acc    = in_valid && in_ready && !flush;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_imm   <= '0;
      r_tag   <= '0;
      r_ill   <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_imm   <= w_imm;
      r_tag   <= in_tag;
      r_ill   <= w_ill;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_cnt <= '0;
    else if (cnt_clr)                      r_cnt <= '0;
    else if (w_acc && w_ill && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  end
  assign out_valid   = r_valid;
  assign out_imm     = r_imm;
  assign out_tag     = r_tag;
  assign out_illegal = r_ill;
  assign illegal_cnt = r_cnt;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: table-driven scoreboard bench for the 32-bit stage plus a 64-bit auto-decode instance
module tb_imm_gen_stage;
  typedef struct {
    logic [2:0]  src;
    logic [31:0] inst;
    logic [4:0]  tag;
    logic [31:0] imm;
    logic        ill;
  } vec_t;
  typedef struct {
    logic [31:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;
  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm;
    logic        ill;
  } v64_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1, cnt_clr = 1'b0;
  logic [31:0] in_inst = '0;
  logic [4:0]  in_tag = '0;
  logic [2:0]  imm_src = '0;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;
  logic [7:0]  illegal_cnt;
  logic        in_valid64 = 1'b0;
  logic [31:0] in_inst64 = '0;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [4:0]  out_tag64;
  logic [7:0]  illegal_cnt64;
  int tests = 0, fails = 0;
  exp_t q[$];
  exp_t cur;
  logic [7:0] exp_cnt = '0;
  bit acc_f;
  always #5 clk = ~clk;
  imm_gen_stage #(.XLEN(32), .AUTO_DECODE(1'b0), .TAG_W(5), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_tag(in_tag), .imm_src(imm_src), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_tag(out_tag), .out_illegal(out_illegal), .cnt_clr(cnt_clr),
    .illegal_cnt(illegal_cnt)
  );
  imm_gen_stage #(.XLEN(64), .AUTO_DECODE(1'b1), .TAG_W(5), .CNT_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64), .in_inst(in_inst64),
    .in_tag(5'h07), .imm_src(3'b111), .flush(1'b0), .out_valid(out_valid64), .out_ready(1'b1),
    .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_illegal64), .cnt_clr(1'b0),
    .illegal_cnt(illegal_cnt64)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // One clock of bookkeeping: inputs are already driven; predict the edge, then check after it
  task automatic cycle();
    exp_t e;
    #1;
    if (out_valid && out_ready && q.size() != 0) begin
      e = q.pop_front();
      chk("out_imm", out_imm, e.imm);
      chk("out_tag", out_tag, e.tag);
      chk("out_illegal", out_illegal, e.ill);
    end
    if (flush) q.delete();
    acc_f = in_valid && in_ready && !flush;
    if (acc_f) q.push_back(cur);
    if (cnt_clr) exp_cnt = '0;
    else if (acc_f && cur.ill && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    @(negedge clk);
    chk("out_valid", out_valid, q.size() != 0);
    chk("illegal_cnt", illegal_cnt, exp_cnt);
  endtask
  task automatic send(input vec_t v, input bit rnd);
    in_valid = 1'b1; imm_src = v.src; in_inst = v.inst; in_tag = v.tag;
    cur.imm = v.imm; cur.tag = v.tag; cur.ill = v.ill;
    acc_f = 1'b0;
    for (int k = 0; k < 40 && !acc_f; k++) begin
      if (rnd) out_ready = (k > 30) ? 1'b1 : 1'(($urandom_range(0, 1)));
      cycle();
    end
    if (!acc_f) begin
      fails++;
      $display("FAIL accept_timeout: got no accept expected accept within 40 cycles");
    end
    in_valid = 1'b0;
  endtask
  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) cycle();
  endtask
  vec_t tv[12];
  v64_t t64[7];
  vec_t ill_v, va, vb;
  logic [31:0] held;
  logic [7:0]  cnt_before;
  initial begin
    tv[0]  = '{3'b010, 32'hFE000EE3, 5'h01, 32'hFFFFFFFC, 1'b0};
    tv[1]  = '{3'b000, 32'h80000013, 5'h02, 32'hFFFFF800, 1'b0};
    tv[2]  = '{3'b000, 32'h7FF00093, 5'h03, 32'h000007FF, 1'b0};
    tv[3]  = '{3'b001, 32'hFE000C23, 5'h04, 32'hFFFFFFF8, 1'b0};
    tv[4]  = '{3'b011, 32'h12345037, 5'h05, 32'h12345000, 1'b0};
    tv[5]  = '{3'b011, 32'hABCDE0B7, 5'h06, 32'hABCDE000, 1'b0};
    tv[6]  = '{3'b100, 32'hFFDFF06F, 5'h07, 32'hFFFFFFFC, 1'b0};
    tv[7]  = '{3'b100, 32'h0080006F, 5'h08, 32'h00000008, 1'b0};
    tv[8]  = '{3'b101, 32'h03F01013, 5'h09, 32'h0000001F, 1'b0};
    tv[9]  = '{3'b110, 32'hFFFFFFFF, 5'h0A, 32'h0000001F, 1'b0};
    tv[10] = '{3'b111, 32'hFFFFFFFF, 5'h1A, 32'h00000000, 1'b1};
    tv[11] = '{3'b001, 32'h00000FA3, 5'h1F, 32'h0000001F, 1'b0};
    t64[0] = '{32'h03F01013, 64'h000000000000003F, 1'b0};
    t64[1] = '{32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    t64[2] = '{32'hABCDE0B7, 64'hFFFFFFFFABCDE000, 1'b0};
    t64[3] = '{32'h0000007F, 64'h0000000000000000, 1'b1};
    t64[4] = '{32'h000FD073, 64'h000000000000001F, 1'b0};
    t64[5] = '{32'h80000013, 64'hFFFFFFFFFFFFF800, 1'b0};
    t64[6] = '{32'h40505013, 64'h0000000000000005, 1'b0};
    ill_v  = '{3'b111, 32'h00000000, 5'h15, 32'h0, 1'b1};
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_imm", out_imm, 32'h0);
    chk("rst_out_tag", out_tag, 5'h0);
    chk("rst_out_illegal", out_illegal, 1'b0);
    chk("rst_illegal_cnt", illegal_cnt, 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid64 = 1'b1; in_inst64 = t64[i].inst;
      @(negedge clk);
      in_valid64 = 1'b0;
      chk("x64_valid", out_valid64, 1'b1);
      chk("x64_imm", out_imm64, t64[i].imm);
      chk("x64_illegal", out_illegal64, t64[i].ill);
    end
    @(negedge clk);
    chk("x64_cnt", illegal_cnt64, 8'h01);
    for (int i = 0; i < 12; i++) send(tv[i], 1'b1);
    drain();
    va = tv[1]; vb = tv[6];
    out_ready = 1'b0;
    send(va, 1'b0);
    held = out_imm;
    send_hold: for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; imm_src = vb.src; in_inst = vb.inst; in_tag = vb.tag;
      cur.imm = vb.imm; cur.tag = vb.tag; cur.ill = vb.ill;
      #1;
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_imm_stable", out_imm, held);
      chk("stall_tag_stable", out_tag, va.tag);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    chk("stall_release_accept", acc_f, 1'b1);
    chk("stall_release_imm", out_imm, vb.imm);
    in_valid = 1'b0;
    drain();
    cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
    chk("cnt_clear", illegal_cnt, 8'h00);
    for (int i = 0; i < 256; i++) send(ill_v, 1'b0);
    drain();
    chk("cnt_saturate", illegal_cnt, 8'hFF);
    cnt_clr = 1'b1;
    send(ill_v, 1'b0);
    cnt_clr = 1'b0;
    chk("cnt_clr_wins", illegal_cnt, 8'h00);
    drain();
    out_ready = 1'b0;
    send(tv[4], 1'b0);
    cnt_before = illegal_cnt;
    flush = 1'b1; in_valid = 1'b1; imm_src = 3'b111; in_tag = 5'h11;
    cur.imm = 32'h0; cur.tag = 5'h11; cur.ill = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_cnt", illegal_cnt, cnt_before);
    out_ready = 1'b0;
    send(ill_v, 1'b0);
    chk("pre_reset_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_cnt", illegal_cnt, 8'h00);
    chk("async_rst_imm", out_imm, 32'h0);
    q.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(tv[0], 1'b0);
    chk("post_reset_first_accept", out_valid, 1'b1);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
